ecc_secded_dec_pipe: RTL and testbench

Pipelined, parametrised SECDED (single-error-correct, double-error-detect) Hamming decoder with a valid/ready stream on both sides. It sits on the FIFO read path between storage and the consumer, and generalises the existing 32+7 combinational decoder to any data width. It adds registered stages, backpressure, a detect-only mode, invalid-syndrome detection and saturating error counters.

---
 rtl/ecc_secded_dec_pipe.sv | 173 +++++++++++++++++
 tb/tb_ecc_secded_dec_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined SECDED Hamming decoder with valid/ready on both sides.
// Supports detect-only mode, flags invalid syndromes and keeps saturating error counters.
module ecc_secded_dec_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ECC_WIDTH  = 7,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ECC_WIDTH-1:0]  in_ecc,
  input  logic                  correct_en,
  input  logic                  cnt_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sbe,
  output logic                  out_dbe,
  output logic [ECC_WIDTH-1:0]  out_syndrome,
  output logic [CNT_WIDTH-1:0]  sbe_cnt,
  output logic [CNT_WIDTH-1:0]  dbe_cnt,
  output logic                  err_irq
);
  localparam int N  = DATA_WIDTH + ECC_WIDTH - 1;
  localparam int SW = ECC_WIDTH - 1;
  localparam logic [SW-1:0]        LAST_POS = SW'(N);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  // Positions 1..N whose index has bit b set; these feed syndrome bit b+1.
  function automatic logic [N:1] f_cover_mask(input int b);
    logic [N:1] m;
    m = '0;
    for (int p = 1; p <= N; p++) begin
      m[p] = ((p >> b) & 1) != 0;
    end
    return m;
  endfunction

  logic                  w_en;
  logic [N:1]            w_cw;
  logic [ECC_WIDTH-1:0]  w_syn;

  logic                  r1_valid;
  logic [DATA_WIDTH-1:0] r1_data;
  logic [ECC_WIDTH-1:0]  r1_syn;
  logic                  r1_corr;

  logic [SW-1:0]         w_pos;
  logic                  w_par;
  logic                  w_sbe;
  logic                  w_dbe;
  logic [DATA_WIDTH-1:0] w_flip_data;
  logic [DATA_WIDTH-1:0] w_dec_data;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_sbe;
  logic                  r_out_dbe;
  logic [ECC_WIDTH-1:0]  r_out_syn;
  logic [CNT_WIDTH-1:0]  r_sbe_cnt;
  logic [CNT_WIDTH-1:0]  r_dbe_cnt;
  logic                  r_err_irq;
  logic                  w_take;

  // Whole pipe advances together; a held output freezes both stages.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Power-of-two positions carry check bits, all others carry data in ascending order.
  for (genvar gi = 1; gi <= N; gi++) begin : g_map
    if ((gi & (gi - 1)) == 0) begin : g_chk
      assign w_cw[gi] = in_ecc[$clog2(gi) + 1];
    end else begin : g_dat
      assign w_cw[gi] = in_data[gi - $clog2(gi + 1) - 1];
    end
  end

  for (genvar gk = 1; gk < ECC_WIDTH; gk++) begin : g_syn
    localparam logic [N:1] MASK = f_cover_mask(gk - 1);
    assign w_syn[gk] = ^(w_cw & MASK);
  end
  assign w_syn[0] = (^w_cw) ^ in_ecc[0];

  // Once the syndrome is captured, only the data half of the codeword is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_data  <= '0;
      r1_syn   <= '0;
      r1_corr  <= 1'b0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_data <= in_data;
        r1_syn  <= w_syn;
        r1_corr <= correct_en;
      end
    end
  end

  assign w_pos = r1_syn[ECC_WIDTH-1:1];
  assign w_par = r1_syn[0];

  always_comb begin
    w_sbe = 1'b0;
    w_dbe = 1'b0;
    if (w_par) begin
      if (w_pos <= LAST_POS) w_sbe = 1'b1;
      else                   w_dbe = 1'b1;
    end else if (w_pos != '0) begin
      w_dbe = 1'b1;
    end
  end

  // A syndrome pointing at a check position flips no data bit.
  for (genvar gi = 1; gi <= N; gi++) begin : g_flip
    if ((gi & (gi - 1)) != 0) begin : g_dat
      localparam logic [SW-1:0] POS = SW'(gi);
      assign w_flip_data[gi - $clog2(gi + 1) - 1] = (w_pos == POS);
    end
  end

  assign w_dec_data = (w_sbe && r1_corr) ? (r1_data ^ w_flip_data) : r1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sbe   <= 1'b0;
      r_out_dbe   <= 1'b0;
      r_out_syn   <= '0;
    end else if (w_en) begin
      r_out_valid <= r1_valid;
      if (r1_valid) begin
        r_out_data <= w_dec_data;
        r_out_sbe  <= w_sbe;
        r_out_dbe  <= w_dbe;
        r_out_syn  <= r1_syn;
      end
    end
  end

  assign w_take = r_out_valid && out_ready;

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbe_cnt <= '0;
      r_dbe_cnt <= '0;
      r_err_irq <= 1'b0;
    end else if (cnt_clr) begin
      r_sbe_cnt <= '0;
      r_dbe_cnt <= '0;
      r_err_irq <= 1'b0;
    end else if (w_take) begin
      if (r_out_sbe && (r_sbe_cnt != CNT_MAX)) r_sbe_cnt <= r_sbe_cnt + 1'b1;
      if (r_out_dbe && (r_dbe_cnt != CNT_MAX)) r_dbe_cnt <= r_dbe_cnt + 1'b1;
      if (r_out_dbe) r_err_irq <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_sbe      = r_out_sbe;
  assign out_dbe      = r_out_dbe;
  assign out_syndrome = r_out_syn;
  assign sbe_cnt      = r_sbe_cnt;
  assign dbe_cnt      = r_dbe_cnt;
  assign err_irq      = r_err_irq;

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// Directed bench for ecc_secded_dec_pipe: vector table plus backpressure, saturation
// and mid-flight reset sequences; counters use a 2-bit width so saturation is reachable.
module tb_ecc_secded_dec_pipe;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int CW = 2;
  localparam int NV = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [EW-1:0] in_ecc = '0;
  logic          correct_en = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sbe;
  logic          out_dbe;
  logic [EW-1:0] out_syndrome;
  logic [CW-1:0] sbe_cnt;
  logic [CW-1:0] dbe_cnt;
  logic          err_irq;

  ecc_secded_dec_pipe #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ecc(in_ecc),
    .correct_en(correct_en), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sbe(out_sbe), .out_dbe(out_dbe), .out_syndrome(out_syndrome),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [EW-1:0] ecc;
    logic          corr;
    logic [DW-1:0] exp_data;
    logic          exp_sbe;
    logic          exp_dbe;
    logic [EW-1:0] exp_syn;
  } vec_t;

  vec_t vecs[NV];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_sbe_cnt = 0;
  int   exp_dbe_cnt = 0;
  int   exp_irq = 0;

  function automatic vec_t mk(input logic [DW-1:0] d, input logic [EW-1:0] e, input logic c,
                              input logic [DW-1:0] xd, input logic xs, input logic xb,
                              input logic [EW-1:0] xy);
    vec_t v;
    v.data = d; v.ecc = e; v.corr = c;
    v.exp_data = xd; v.exp_sbe = xs; v.exp_dbe = xb; v.exp_syn = xy;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // One word through an empty pipe: latency, decode result, then counter update on acceptance.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.data; in_ecc = v.ecc; correct_en = v.corr; out_ready = 1'b1;
    chk("in_ready", idx, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_ecc = '0; correct_en = ~v.corr;
    chk("valid_after_1", idx, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("valid_after_2", idx, 64'(out_valid), 64'd1);
    chk("data", idx, 64'(out_data), 64'(v.exp_data));
    chk("sbe", idx, 64'(out_sbe), 64'(v.exp_sbe));
    chk("dbe", idx, 64'(out_dbe), 64'(v.exp_dbe));
    chk("syndrome", idx, 64'(out_syndrome), 64'(v.exp_syn));
    $display("vec %0d: data=%h ecc=%h corr=%b -> out=%h sbe=%b dbe=%b syn=%h",
             idx, v.data, v.ecc, v.corr, out_data, out_sbe, out_dbe, out_syndrome);
    if (v.exp_sbe && exp_sbe_cnt < 3) exp_sbe_cnt++;
    if (v.exp_dbe && exp_dbe_cnt < 3) exp_dbe_cnt++;
    if (v.exp_dbe) exp_irq = 1;
    @(negedge clk);
    chk("valid_drained", idx, 64'(out_valid), 64'd0);
    chk("sbe_cnt", idx, 64'(sbe_cnt), 64'(exp_sbe_cnt));
    chk("dbe_cnt", idx, 64'(dbe_cnt), 64'(exp_dbe_cnt));
    chk("err_irq", idx, 64'(err_irq), 64'(exp_irq));
  endtask

  task automatic clear_counters(input int idx);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_sbe_cnt = 0; exp_dbe_cnt = 0; exp_irq = 0;
    chk("clr_sbe_cnt", idx, 64'(sbe_cnt), 64'd0);
    chk("clr_dbe_cnt", idx, 64'(dbe_cnt), 64'd0);
    chk("clr_irq", idx, 64'(err_irq), 64'd0);
  endtask

  function automatic logic [DW-1:0] bp_word(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  initial begin
    logic [DW-1:0] got[8];
    int sent, rcvd, stalls, stall_err, hold_err;
    logic prev_stall;
    logic [DW-1:0] prev_data;

    //          data          ecc    c  exp_data      sbe   dbe   syn
    vecs[0]  = mk(32'h0,        7'h00, 1, 32'h0,        1'b0, 1'b0, 7'h00);
    vecs[1]  = mk(32'h20,       7'h00, 1, 32'h0,        1'b1, 1'b0, 7'h15);
    vecs[2]  = mk(32'h3,        7'h00, 1, 32'h3,        1'b0, 1'b1, 7'h0C);
    vecs[3]  = mk(32'h0,        7'h01, 1, 32'h0,        1'b1, 1'b0, 7'h01);
    vecs[4]  = mk(32'h20,       7'h00, 0, 32'h20,       1'b1, 1'b0, 7'h15);
    vecs[5]  = mk(32'h0,        7'h02, 1, 32'h0,        1'b1, 1'b0, 7'h03);
    vecs[6]  = mk(32'h80000000, 7'h00, 1, 32'h0,        1'b1, 1'b0, 7'h4D);
    vecs[7]  = mk(32'h0,        7'h4F, 1, 32'h0,        1'b0, 1'b1, 7'h4F);
    vecs[8]  = mk(32'h1,        7'h07, 1, 32'h1,        1'b0, 1'b0, 7'h00);
    vecs[9]  = mk(32'h3,        7'h07, 1, 32'h1,        1'b1, 1'b0, 7'h0B);
    vecs[10] = mk(32'h0,        7'h10, 1, 32'h0,        1'b1, 1'b0, 7'h11);
    vecs[11] = mk(32'h3,        7'h00, 0, 32'h3,        1'b0, 1'b1, 7'h0C);
    vecs[12] = mk(32'h1,        7'h07, 0, 32'h1,        1'b0, 1'b0, 7'h00);
    vecs[13] = mk(32'h3,        7'h07, 0, 32'h3,        1'b1, 1'b0, 7'h0B);

    #12;
    chk("rst_out_valid", 0, 64'(out_valid), 64'd0);
    chk("rst_out_data", 0, 64'(out_data), 64'd0);
    chk("rst_flags", 0, 64'({out_sbe, out_dbe}), 64'd0);
    chk("rst_syndrome", 0, 64'(out_syndrome), 64'd0);
    chk("rst_counters", 0, 64'({sbe_cnt, dbe_cnt, err_irq}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 0, 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    clear_counters(100);

    // Backpressure: out_ready pattern 1,0,0,1 while streaming 8 raw-passthrough words.
    sent = 0; rcvd = 0; stalls = 0; stall_err = 0; hold_err = 0;
    prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 200 && rcvd < 8; cyc++) begin
      @(negedge clk);
      out_ready  = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      in_valid   = (sent < 8);
      in_data    = bp_word(sent);
      in_ecc     = '0;
      correct_en = 1'b0;
      #1;
      if (prev_stall && out_data !== prev_data) hold_err++;
      if (out_valid && !out_ready) begin
        stalls++;
        if (in_ready !== 1'b0) stall_err++;
      end
      if (out_valid && out_ready) begin
        got[rcvd] = out_data;
        $display("bp recv %0d: out=%h", rcvd, out_data);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", 200, 64'(rcvd), 64'd8);
    for (int i = 0; i < 8; i++) chk("bp_order", 200 + i, 64'(got[i]), 64'(bp_word(i)));
    chk("bp_stall_in_ready", 200, 64'(stall_err), 64'd0);
    chk("bp_hold", 200, 64'(hold_err), 64'd0);
    chk("bp_stalls_seen", 200, 64'(stalls > 0), 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_drained", 200, 64'(out_valid), 64'd0);

    clear_counters(300);

    // Saturation: five back-to-back single-error words with a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h20; in_ecc = '0; correct_en = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_sbe_cnt", 400, 64'(sbe_cnt), 64'd3);
    $display("sat: sbe_cnt=%0d after 5 single-error words", sbe_cnt);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h20;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("sat_6th_valid", 401, 64'(out_valid), 64'd1);
    chk("sat_6th_sbe", 401, 64'(out_sbe), 64'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_wins", 401, 64'(sbe_cnt), 64'd0);
    $display("sat: clear with 6th accept -> sbe_cnt=%0d", sbe_cnt);
    exp_sbe_cnt = 0; exp_dbe_cnt = 0; exp_irq = 0;

    // Mid-flight reset with non-zero counters and two words in the pipe.
    run_vec(500, vecs[2]);
    run_vec(501, vecs[1]);
    @(negedge clk);
    in_valid = 1'b1; in_data = vecs[1].data; in_ecc = vecs[1].ecc; correct_en = 1'b1;
    @(negedge clk);
    in_data = vecs[9].data; in_ecc = vecs[9].ecc;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("inflight_valid", 502, 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 502, 64'(out_valid), 64'd0);
    chk("arst_counters", 502, 64'({sbe_cnt, dbe_cnt}), 64'd0);
    chk("arst_irq", 502, 64'(err_irq), 64'd0);
    $display("reset: mid-flight reset asserted, out_valid=%b sbe_cnt=%0d dbe_cnt=%0d", out_valid, sbe_cnt, dbe_cnt);
    exp_sbe_cnt = 0; exp_dbe_cnt = 0; exp_irq = 0;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 503, 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("no_partial_1", 503, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("no_partial_2", 503, 64'(out_valid), 64'd0);
    run_vec(504, vecs[9]);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
